// File: rtl/fetch_unit.sv
// fetch_unit: sequential instruction fetch with a two-entry output buffer.
// Works with a one-cycle synchronous instruction memory. At most one fetch is
// in flight at a time. Issue is throttled so the returning word always finds
// a free buffer slot. A redirect flushes the buffer and any in-flight fetch,
// then restarts fetching at the word-aligned target.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2             // buffer entries; only 2 is supported
) (
  input  logic        clk,
  input  logic        reset,            // asynchronous, active-low
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_inst,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc
);

  // Buffer capacity expressed in the width of the occupancy arithmetic.
  localparam logic [2:0] CAPACITY = 3'(DEPTH);

  // Architectural state.
  logic [31:0] pc_q, pc_d;
  logic        inflight_q, inflight_d;
  logic [31:0] inflight_pc_q, inflight_pc_d;
  logic [1:0]  count_q, count_d;
  logic        rd_ptr_q, rd_ptr_d;
  logic        wr_ptr_q, wr_ptr_d;

  // Buffer storage: one instruction word and its byte address per entry.
  logic [31:0] fifo_inst_q [DEPTH];
  logic [31:0] fifo_pc_q   [DEPTH];
  logic [DEPTH-1:0] entry_we;

  // Handshake and control terms.
  logic        pop;
  logic        push;
  logic        issue;
  logic [2:0]  occupancy;

  // The low two bits of the redirect target are dropped on purpose.
  logic        unused_redirect_lsbs;
  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  // The head is valid whenever the buffer holds anything.
  assign out_valid = (count_q != 2'd0);
  assign out_inst  = fifo_inst_q[rd_ptr_q];
  assign out_pc    = fifo_pc_q[rd_ptr_q];
  assign imem_addr = pc_q;

  // Derive pop/push/issue; issue only when the next word will have room.
  always_comb begin
    pop       = out_valid && out_ready;
    push      = inflight_q && !redirect_valid;
    // pop implies count_q >= 1, so the subtraction cannot underflow.
    occupancy = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
    issue     = !redirect_valid && (occupancy < CAPACITY);
  end

  // Next-state logic: redirect flushes everything, otherwise fetch/push/pop.
  always_comb begin
    pc_d          = pc_q;
    inflight_d    = inflight_q;
    inflight_pc_d = inflight_pc_q;
    count_d       = count_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;

    if (redirect_valid) begin
      // A head popped this cycle is still delivered; everything else is dropped.
      pc_d       = {redirect_pc[31:2], 2'b00};
      inflight_d = 1'b0;
      count_d    = 2'd0;
      rd_ptr_d   = 1'b0;
      wr_ptr_d   = 1'b0;
    end else begin
      // The in-flight flag tracks exactly whether a fetch was issued this cycle.
      inflight_d = issue;
      if (issue) begin
        inflight_pc_d = pc_q;
        pc_d          = pc_q + 32'd4;  // wraps modulo 2^32
      end
      if (push) begin
        wr_ptr_d = ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;    // idle, or push and pop together
      endcase
    end
  end

  // Control and pointer registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= 32'h0000_0000;
      count_q       <= 2'd0;
      rd_ptr_q      <= 1'b0;
      wr_ptr_q      <= 1'b0;
    end else begin
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      count_q       <= count_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
    end
  end

  // Per-entry storage; each entry captures the returning word when it is the tail.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    assign entry_we[gi] = push && (wr_ptr_q == 1'(gi));

    // Entry register, cleared by reset so the idle head reads as zero.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        fifo_inst_q[gi] <= 32'h0000_0000;
        fifo_pc_q[gi]   <= 32'h0000_0000;
      end else if (entry_we[gi]) begin
        fifo_inst_q[gi] <= imem_inst;
        fifo_pc_q[gi]   <= inflight_pc_q;
      end
    end
  end

endmodule
